// File: rtl/load_store_unit_if.sv
// Data-bus interface between the load/store unit (master) and memory (slave).
// Single-outstanding request channel with req/ack handshake.
interface load_store_unit_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              bus_req;
    logic              bus_we;
    logic [3:0]        bus_be;
    logic [ADDR_W-1:0] bus_addr;
    logic [31:0]       bus_wdata;
    logic              bus_ack;
    logic [31:0]       bus_rdata;

    modport master (
        output bus_req, bus_we, bus_be, bus_addr, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_be, bus_addr, bus_wdata,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: byte-lane generation, store data replication,
// load extraction/extension, and pipeline stall while an access is in flight.
// Optional feature macro: LSU_TIMEOUT_EN (aborts a BUSY access after
// TIMEOUT_CYCLES cycles without ack and pulses bus_err).
module load_store_unit #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid,
    input  logic [2:0]        mem_read,
    input  logic [1:0]        mem_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              stall,
    output logic [31:0]       rdata,
    output logic              rdata_valid,
    output logic              misaligned,
    output logic              bus_err,
    load_store_unit_if.master bus
);

    localparam logic [2:0] LD_LW  = 3'd0;
    localparam logic [2:0] LD_LH  = 3'd1;
    localparam logic [2:0] LD_LHU = 3'd2;
    localparam logic [2:0] LD_LB  = 3'd3;
    localparam logic [2:0] LD_LBU = 3'd4;

    localparam logic [1:0] ST_SW   = 2'd0;
    localparam logic [1:0] ST_SH   = 2'd1;
    localparam logic [1:0] ST_SB   = 2'd2;
    localparam logic [1:0] ST_NONE = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Degenerate configurations are rejected at elaboration.
    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end
    if (ADDR_W < 3) begin : g_bad_addr_w
        $error("ADDR_W must be at least 3");
    end

    state_e            state_q, state_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_we_q, bus_we_d;
    logic [3:0]        bus_be_q, bus_be_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [31:0]       bus_wdata_q, bus_wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              rdata_valid_q, rdata_valid_d;
    logic              misaligned_q, misaligned_d;
    logic [2:0]        ld_op_q, ld_op_d;
    logic [1:0]        off_q, off_d;

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              bus_err_q, bus_err_d;
`endif

    logic        is_store_c;
    logic        is_load_c;
    logic        access_c;
    logic        half_c;
    logic        word_c;
    logic        misalign_c;
    logic        accept_c;
    logic [3:0]  st_be_c;
    logic [31:0] st_data_c;
    logic [7:0]  ld_byte_c;
    logic [15:0] ld_half_c;
    logic [31:0] ld_data_c;

    // Decode the access: store wins over load, then classify size and alignment.
    always_comb begin
        is_store_c = (mem_write != ST_NONE);
        is_load_c  = (mem_read <= LD_LBU);
        access_c   = valid && (is_store_c || is_load_c);
        half_c     = 1'b0;
        word_c     = 1'b0;
        if (is_store_c) begin
            word_c = (mem_write == ST_SW);
            half_c = (mem_write == ST_SH);
        end else begin
            word_c = (mem_read == LD_LW);
            half_c = (mem_read == LD_LH) || (mem_read == LD_LHU);
        end
        misalign_c = (half_c && addr[0]) || (word_c && (addr[1:0] != 2'b00));
        accept_c   = (state_q == IDLE) && access_c && !misalign_c;
    end

    // Store byte lanes and replicated write data.
    always_comb begin
        st_be_c   = 4'b1111;
        st_data_c = wdata;
        case (mem_write)
            ST_SB: begin
                st_be_c   = 4'b0001 << addr[1:0];
                st_data_c = {4{wdata[7:0]}};
            end
            ST_SH: begin
                st_be_c   = addr[1] ? 4'b1100 : 4'b0011;
                st_data_c = {2{wdata[15:0]}};
            end
            default: begin
                st_be_c   = 4'b1111;
                st_data_c = wdata;
            end
        endcase
    end

    // Shift the addressed byte/half down and extend it per load type.
    always_comb begin
        case (off_q)
            2'd0:    ld_byte_c = bus.bus_rdata[7:0];
            2'd1:    ld_byte_c = bus.bus_rdata[15:8];
            2'd2:    ld_byte_c = bus.bus_rdata[23:16];
            default: ld_byte_c = bus.bus_rdata[31:24];
        endcase
        ld_half_c = off_q[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
        case (ld_op_q)
            LD_LH:   ld_data_c = {{16{ld_half_c[15]}}, ld_half_c};
            LD_LHU:  ld_data_c = {16'h0000, ld_half_c};
            LD_LB:   ld_data_c = {{24{ld_byte_c[7]}}, ld_byte_c};
            LD_LBU:  ld_data_c = {24'h000000, ld_byte_c};
            default: ld_data_c = bus.bus_rdata;
        endcase
    end

    // Next-state and registered-output logic of the access FSM.
    always_comb begin
        state_d       = state_q;
        bus_req_d     = bus_req_q;
        bus_we_d      = bus_we_q;
        bus_be_d      = bus_be_q;
        bus_addr_d    = bus_addr_q;
        bus_wdata_d   = bus_wdata_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        misaligned_d  = 1'b0;
        ld_op_d       = ld_op_q;
        off_d         = off_q;
`ifdef LSU_TIMEOUT_EN
        cnt_d         = cnt_q;
        bus_err_d     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (access_c) begin
                    if (misalign_c) begin
                        misaligned_d = 1'b1;
                    end else begin
                        state_d     = BUSY;
                        bus_req_d   = 1'b1;
                        bus_we_d    = is_store_c;
                        bus_be_d    = is_store_c ? st_be_c : 4'b1111;
                        bus_addr_d  = {addr[ADDR_W-1:2], 2'b00};
                        bus_wdata_d = is_store_c ? st_data_c : 32'h0000_0000;
                        ld_op_d     = mem_read;
                        off_d       = addr[1:0];
`ifdef LSU_TIMEOUT_EN
                        cnt_d       = '0;
`endif
                    end
                end
            end
            BUSY: begin
                if (bus.bus_ack) begin
                    bus_req_d = 1'b0;
                    state_d   = DONE;
                    if (!bus_we_q) begin
                        rdata_d       = ld_data_c;
                        rdata_valid_d = 1'b1;
                    end
                end
`ifdef LSU_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    bus_req_d = 1'b0;
                    state_d   = DONE;
                    bus_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            bus_req_q     <= 1'b0;
            bus_we_q      <= 1'b0;
            bus_be_q      <= 4'b0000;
            bus_addr_q    <= '0;
            bus_wdata_q   <= 32'h0000_0000;
            rdata_q       <= 32'h0000_0000;
            rdata_valid_q <= 1'b0;
            misaligned_q  <= 1'b0;
            ld_op_q       <= 3'd0;
            off_q         <= 2'd0;
        end else begin
            state_q       <= state_d;
            bus_req_q     <= bus_req_d;
            bus_we_q      <= bus_we_d;
            bus_be_q      <= bus_be_d;
            bus_addr_q    <= bus_addr_d;
            bus_wdata_q   <= bus_wdata_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            misaligned_q  <= misaligned_d;
            ld_op_q       <= ld_op_d;
            off_q         <= off_d;
        end
    end

`ifdef LSU_TIMEOUT_EN
    // BUSY-cycle counter and abort pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
        end
    end
    assign bus_err = bus_err_q;
`else
    assign bus_err = 1'b0;
`endif

    // Stall covers the accept cycle (combinational) and every BUSY cycle.
    assign stall         = accept_c || (state_q == BUSY);
    assign rdata         = rdata_q;
    assign rdata_valid   = rdata_valid_q;
    assign misaligned    = misaligned_q;
    assign bus.bus_req   = bus_req_q;
    assign bus.bus_we    = bus_we_q;
    assign bus.bus_be    = bus_be_q;
    assign bus.bus_addr  = bus_addr_q;
    assign bus.bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a scoreboard of expected bus
// transactions and load results.
module tb_load_store_unit;

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        is_load;
        logic [31:0] rdata;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        valid;
    logic [2:0]  mem_read;
    logic [1:0]  mem_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        misaligned;
    logic        bus_err;

    int   n_assert = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];
    logic [31:0] last_rdata;

    load_store_unit_if #(.ADDR_W(32)) bus_if ();

    load_store_unit #(
        .ADDR_W         (32),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .valid       (valid),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .addr        (addr),
        .wdata       (wdata),
        .stall       (stall),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .misaligned  (misaligned),
        .bus_err     (bus_err),
        .bus         (bus_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no end of test, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic we, input logic [3:0] be, input logic [31:0] a,
                                input logic [31:0] wd, input logic ld, input logic [31:0] rd);
        exp_t e;
        e.we = we; e.be = be; e.addr = a; e.wdata = wd; e.is_load = ld; e.rdata = rd;
        return e;
    endfunction

    task automatic idle_inputs();
        valid     = 1'b0;
        mem_read  = 3'd5;
        mem_write = 2'b11;
    endtask

    // One complete access with ack in the k-th request cycle.
    task automatic do_access(input string tag, input logic [2:0] mr, input logic [1:0] mw,
                             input logic [31:0] a, input logic [31:0] wd, input int k,
                             input logic [31:0] rsp, input exp_t e);
        int   stall_cycles;
        exp_t h;
        stall_cycles = 0;
        @(posedge clk); #1;
        valid = 1'b1; mem_read = mr; mem_write = mw; addr = a; wdata = wd;
        sb_q.push_back(e);
        @(negedge clk);
        if (stall === 1'b1) stall_cycles++;
        @(posedge clk); #1;
        idle_inputs();
        for (int c = 1; c <= k; c++) begin
            if (c > 1) begin
                @(posedge clk); #1;
            end
            bus_if.bus_ack   = (c == k);
            bus_if.bus_rdata = rsp;
            @(negedge clk);
            if (stall === 1'b1) stall_cycles++;
            if (c == k) begin
                h = sb_q[0];
                check({tag, ".req"},   32'(bus_if.bus_req), 32'd1);
                check({tag, ".we"},    32'(bus_if.bus_we),  32'(h.we));
                check({tag, ".be"},    32'(bus_if.bus_be),  32'(h.be));
                check({tag, ".addr"},  bus_if.bus_addr,     h.addr);
                if (h.we) check({tag, ".wdata"}, bus_if.bus_wdata, h.wdata);
            end
        end
        @(posedge clk); #1;
        bus_if.bus_ack = 1'b0;
        @(negedge clk);
        h = sb_q.pop_front();
        check({tag, ".stall_cycles"}, 32'(stall_cycles), 32'(k + 1));
        check({tag, ".done_stall"},   32'(stall),        32'd0);
        check({tag, ".done_req"},     32'(bus_if.bus_req), 32'd0);
        check({tag, ".rvalid"},       32'(rdata_valid),  32'(h.is_load));
        check({tag, ".bus_err"},      32'(bus_err),      32'd0);
        if (h.is_load) last_rdata = h.rdata;
        check({tag, ".rdata"},        rdata,             last_rdata);
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        addr = 32'h0; wdata = 32'h0;
        bus_if.bus_ack   = 1'b0;
        bus_if.bus_rdata = 32'h0;
        last_rdata = 32'h0;

        // Reset values.
        #2;
        check("rst.req",   32'(bus_if.bus_req), 32'd0);
        check("rst.we",    32'(bus_if.bus_we),  32'd0);
        check("rst.be",    32'(bus_if.bus_be),  32'd0);
        check("rst.addr",  bus_if.bus_addr,     32'd0);
        check("rst.wdata", bus_if.bus_wdata,    32'd0);
        check("rst.rdata", rdata,               32'd0);
        check("rst.rv",    32'(rdata_valid),    32'd0);
        check("rst.mis",   32'(misaligned),     32'd0);
        check("rst.err",   32'(bus_err),        32'd0);
        #20 rst_n = 1'b1;

        // Stores.
        do_access("sw", 3'd5, 2'b00, 32'h100, 32'hDEADBEEF, 2, 32'h0,
                  mk(1'b1, 4'b1111, 32'h100, 32'hDEADBEEF, 1'b0, 32'h0));
        do_access("sb", 3'd5, 2'b10, 32'h103, 32'h000000A5, 1, 32'h0,
                  mk(1'b1, 4'b1000, 32'h100, 32'hA5A5A5A5, 1'b0, 32'h0));
        do_access("sh", 3'd5, 2'b01, 32'h102, 32'h1234BEEF, 1, 32'h0,
                  mk(1'b1, 4'b1100, 32'h100, 32'hBEEFBEEF, 1'b0, 32'h0));
        do_access("sh_lo", 3'd5, 2'b01, 32'h204, 32'h00005A3C, 2, 32'h0,
                  mk(1'b1, 4'b0011, 32'h204, 32'h5A3C5A3C, 1'b0, 32'h0));

        // Loads with sign/zero extension.
        do_access("lb", 3'd3, 2'b11, 32'h101, 32'h0, 1, 32'h12348056,
                  mk(1'b0, 4'b1111, 32'h100, 32'h0, 1'b1, 32'hFFFFFF80));
        do_access("lbu", 3'd4, 2'b11, 32'h101, 32'h0, 2, 32'h12348056,
                  mk(1'b0, 4'b1111, 32'h100, 32'h0, 1'b1, 32'h00000080));
        do_access("lh", 3'd1, 2'b11, 32'h102, 32'h0, 1, 32'h12348056,
                  mk(1'b0, 4'b1111, 32'h100, 32'h0, 1'b1, 32'h00001234));
        do_access("lh_neg", 3'd1, 2'b11, 32'h100, 32'h0, 1, 32'h00008001,
                  mk(1'b0, 4'b1111, 32'h100, 32'h0, 1'b1, 32'hFFFF8001));
        do_access("lhu", 3'd2, 2'b11, 32'h100, 32'h0, 3, 32'h00008001,
                  mk(1'b0, 4'b1111, 32'h100, 32'h0, 1'b1, 32'h00008001));
        do_access("lbu3", 3'd4, 2'b11, 32'h107, 32'h0, 1, 32'hC3000000,
                  mk(1'b0, 4'b1111, 32'h104, 32'h0, 1'b1, 32'h000000C3));

        // Store takes priority over a simultaneous (here misaligned) LW; rdata holds.
        do_access("prio", 3'd0, 2'b10, 32'h101, 32'h00000077, 2, 32'hFFFFFFFF,
                  mk(1'b1, 4'b0010, 32'h100, 32'h77777777, 1'b0, 32'h0));

        // Misaligned LW: pulse, no bus activity, no stall.
        @(posedge clk); #1;
        valid = 1'b1; mem_read = 3'd0; mem_write = 2'b11; addr = 32'h102;
        @(negedge clk);
        check("mis.stall_t", 32'(stall), 32'd0);
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        check("mis.pulse",   32'(misaligned),     32'd1);
        check("mis.req",     32'(bus_if.bus_req), 32'd0);
        check("mis.stall",   32'(stall),          32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("mis.pulse_end", 32'(misaligned),   32'd0);
        check("mis.req_end",   32'(bus_if.bus_req), 32'd0);

        // Misaligned SH also rejected.
        @(posedge clk); #1;
        valid = 1'b1; mem_read = 3'd5; mem_write = 2'b01; addr = 32'h101;
        @(negedge clk);
        check("mis_sh.stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        check("mis_sh.pulse", 32'(misaligned), 32'd1);

        // Following aligned LW completes normally.
        do_access("lw", 3'd0, 2'b11, 32'h104, 32'h0, 3, 32'hCAFEF00D,
                  mk(1'b0, 4'b1111, 32'h104, 32'h0, 1'b1, 32'hCAFEF00D));

`ifdef LSU_TIMEOUT_EN
        // No ack: abort after 4 BUSY cycles.
        @(posedge clk); #1;
        valid = 1'b1; mem_read = 3'd0; mem_write = 2'b11; addr = 32'h300;
        @(posedge clk); #1;
        idle_inputs();
        for (int c = 1; c <= 4; c++) begin
            if (c > 1) begin
                @(posedge clk); #1;
            end
            @(negedge clk);
            check("to.req_busy", 32'(bus_if.bus_req), 32'd1);
        end
        @(posedge clk); #1;
        @(negedge clk);
        check("to.err",   32'(bus_err),        32'd1);
        check("to.stall", 32'(stall),          32'd0);
        check("to.req",   32'(bus_if.bus_req), 32'd0);
        check("to.rv",    32'(rdata_valid),    32'd0);
        check("to.rdata", rdata,               last_rdata);
        @(posedge clk); #1;
        @(negedge clk);
        check("to.err_end", 32'(bus_err), 32'd0);
`endif

        // Reset in the middle of a held-off load.
        @(posedge clk); #1;
        valid = 1'b1; mem_read = 3'd0; mem_write = 2'b11; addr = 32'h200;
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        check("mr.req_busy", 32'(bus_if.bus_req), 32'd1);
        check("mr.stall",    32'(stall),          32'd1);
        @(posedge clk); #1;
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        last_rdata = 32'h0;
        check("mr.req",   32'(bus_if.bus_req), 32'd0);
        check("mr.be",    32'(bus_if.bus_be),  32'd0);
        check("mr.addr",  bus_if.bus_addr,     32'd0);
        check("mr.rdata", rdata,               32'd0);
        check("mr.stall", 32'(stall),          32'd0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        bus_if.bus_ack   = 1'b1;
        bus_if.bus_rdata = 32'h55AA55AA;
        @(negedge clk);
        check("mr.stray_req", 32'(bus_if.bus_req), 32'd0);
        @(posedge clk); #1;
        bus_if.bus_ack = 1'b0;
        @(negedge clk);
        check("mr.stray_rv",    32'(rdata_valid), 32'd0);
        check("mr.stray_rdata", rdata,            32'd0);

        // Normal operation resumes after reset.
        do_access("post", 3'd4, 2'b11, 32'h202, 32'h0, 1, 32'h00FE0000,
                  mk(1'b0, 4'b1111, 32'h200, 32'h0, 1'b1, 32'h000000FE));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage load/store unit of the pipeline; consumes the decoder's `MemRead`/`MemWrite` codes with the ALU address and rs2 data, and drives a single-outstanding req/ack data bus. Generates byte-lane enables and replicated store data, extracts and sign- or zero-extends load data, and stalls the pipeline while an access is in flight. Sits between the EX/MEM pipeline register and the MEM/WB register.

## Interface
- `ADDR_W`, 32: byte address width.
- `TIMEOUT_CYCLES`, 255: maximum BUSY cycles before abort; used only with `LSU_TIMEOUT_EN`.

- `clk` in 1: clock, all state on rising edge.
- `rst_n` in 1: one clock; reset is asynchronous and active-low.
- `valid` in 1: EX/MEM holds a live instruction.
- `mem_read` in 3: load code: 000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 none; 110/111 treated as none.
- `mem_write` in 2: store code: 00 SW, 01 SH, 10 SB, 11 none.
- `addr` in ADDR_W: byte address (ALU result).
- `wdata` in 32: store data (rs2).
- `stall` out 1: hold PC, IF/ID, ID/EX, EX/MEM.
- `rdata` out 32: extended load result.
- `rdata_valid` out 1: one-cycle pulse, load result valid.
- `misaligned` out 1: one-cycle pulse, access rejected.
- `bus_err` out 1: one-cycle pulse, access aborted by timeout; constant 0 without `LSU_TIMEOUT_EN`.
- `bus_req` out 1, `bus_we` out 1, `bus_be` out 4, `bus_addr` out ADDR_W (bits [1:0] = 0), `bus_wdata` out 32: request channel.
- `bus_ack` in 1, `bus_rdata` in 32: response channel.

## Operation
- States: IDLE, BUSY, DONE.
- Access = `valid` and (store code != 11 or load code in 000–100). Store takes priority if both are active; the load is suppressed.
- IDLE, access, aligned: capture op, `addr[1:0]`, lanes, data → BUSY.
- IDLE, access, misaligned (half with `addr[0]`=1; word with `addr[1:0]`!=0): pulse `misaligned` next cycle, no bus activity, no stall, stay IDLE.
- BUSY: `bus_req`=1 with all request fields stable until `bus_ack` is sampled 1. On ack, capture `bus_rdata` and go to DONE.
- DONE: `stall`=0. For loads, pulse `rdata_valid`. Return to IDLE. `valid` seen in DONE belongs to the completing instruction and is ignored.
- `stall` = (IDLE and aligned access) or BUSY. `stall` is combinational from inputs in IDLE.
- Store lanes:
  - SB: `bus_be` = 1<<addr[1:0]; byte replicated ×4.
  - SH: `bus_be` = 0011 if addr[1]=0, else 1100; half replicated ×2.
  - SW: `bus_be` = 1111.
- Loads: `bus_we`=0, `bus_be`=1111. The selected byte/half is shifted down by `addr[1:0]`. LB/LH sign-extend; LBU/LHU zero-extend.
- `rdata` holds its value until the next load completes.
- `bus_ack` while `bus_req`=0 is ignored.

## Timing
- Reset values: state IDLE, `bus_req`/`bus_we`/`rdata_valid`/`misaligned`/`bus_err` 0, `bus_be` 0000, `bus_addr`/`bus_wdata`/`rdata` 0.
- Accept at cycle T. `bus_req` high from T+1. Ack at T+k (k≥1). DONE at T+k+1.
- `stall` is high T..T+k. Minimum occupancy is 3 cycles.
- `rdata_valid` and `rdata` update in the DONE cycle.
- Registered outputs: `bus_*` request fields, `rdata`, and pulses.
- `rst_n` low mid-access: `bus_req` drops asynchronously and state goes to IDLE. A late ack is ignored.

## Configuration
- `LSU_TIMEOUT_EN` defined:
  - BUSY counter is cleared on entry.
  - At `TIMEOUT_CYCLES` cycles without ack: drop `bus_req`, enter DONE, pulse `bus_err`, no `rdata_valid`, `rdata` unchanged.
- Undefined: BUSY waits indefinitely, no counter, `bus_err` tied 0.

## Test plan
- SW: addr 0x100, wdata 0xDEADBEEF, ack 2 cycles after req → `bus_be`=1111, `bus_addr`=0x100, `stall` 3 cycles, no `rdata_valid`.
- SB: addr 0x103, wdata 0x000000A5 → `bus_be`=1000, `bus_wdata`=0xA5A5A5A5. Then SH to 0x102 → `bus_be`=1100, data replicated.
- LB vs LBU: addr 0x101, `bus_rdata`=0x12348056 → LB `rdata`=0xFFFFFF80, LBU `rdata`=0x00000080. LH at 0x102 → 0x00001234.
- LW at addr 0x102 → `misaligned` pulse, `bus_req` stays 0, `stall` 0. The following aligned LW completes normally.
- Load with ack held off, `rst_n` pulsed low mid-BUSY → `bus_req` 0 immediately, all outputs at reset values. Subsequent stray ack produces no `rdata_valid`.
- With `LSU_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4, no ack → `bus_err` pulse after 4 BUSY cycles, `stall` released, `rdata` unchanged.
